serial_sub: RTL and testbench

- Bit-serial N-bit subtractor; computes {bout, diff} = a - b - bin over WIDTH clock cycles, LSB first.
- Uses one full-subtractor cell plus a registered borrow, instead of a WIDTH-bit combinational ripple chain.
- A start/busy/done handshake drives it; it sits beside the combinational subtractor library as the area-minimal sequential option.

---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/serial_sub_fs_cell.sv | 28 ++
 rtl/serial_sub.sv | 142 ++++++++++++++
 tb/tb_serial_sub.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared encodings and width limits for the bit-serial subtractor.
// Optional add mode is enabled by defining SERIAL_SUB_ADD_MODE_EN.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_legal(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_sub_fs_cell.sv
// One-bit full subtractor cell; becomes a full adder/subtractor when
// SERIAL_SUB_ADD_MODE_EN is defined (mode=1 selects addition).
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bi,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic mode,
`endif
  output logic d,
  output logic bo
);

  // Sum/difference bit is the same XOR for both operations.
  always_comb begin
    d  = a ^ b ^ bi;
`ifdef SERIAL_SUB_ADD_MODE_EN
    if (mode) begin
      bo = (a & b) | ((a ^ b) & bi);
    end else begin
      bo = (~a & b) | (~(a ^ b) & bi);
    end
`else
    bo = (~a & b) | (~(a ^ b) & bi);
`endif
  end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor, LSB first, start/busy/done handshake.
// Define SERIAL_SUB_ADD_MODE_EN to add a 'mode' port selecting addition.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d, b_sr_q, b_sr_d;
  logic [WIDTH-2:0]   res_sr_q, res_sr_d;
  logic [WIDTH-1:0]   shifted_s;
  logic               brw_q, brw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               cell_d, cell_bo;
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic               mode_q, mode_d;
`endif

  fs_cell u_cell (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .bi  (brw_q),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .mode(mode_q),
`endif
    .d   (cell_d),
    .bo  (cell_bo)
  );

  // res_sr keeps only the WIDTH-1 bits already produced; the new bit joins on top.
  assign shifted_s = {cell_d, res_sr_q};

  // Next-state, datapath shifting and result capture.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    brw_d    = brw_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_ADD_MODE_EN
    mode_d   = mode_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          brw_d    = bin;
          res_sr_d = '0;
          cnt_d    = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
          mode_d   = mode;
`endif
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        res_sr_d = shifted_s[WIDTH-1:1];
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        brw_d    = cell_bo;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          diff_d  = shifted_s;
          bout_d  = cell_bo;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      mode_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      brw_q    <= brw_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
      mode_q   <= mode_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: WIDTH=8 and WIDTH=3 instances against a timeline model.
module tb_serial_sub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        start_i = 2'b00;
  logic [1:0][31:0]  a_i     = '0;
  logic [1:0][31:0]  b_i     = '0;
  logic [1:0]        bin_i   = 2'b00;
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic [1:0]        mode_i  = 2'b00;
`endif
  logic [1:0]        busy_o, done_o, bout_o;
  logic [7:0]        diff8;
  logic [2:0]        diff3;

  int n_tests = 0;
  int n_fail  = 0;

  serial_sub #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start_i[0]),
    .a(a_i[0][7:0]), .b(b_i[0][7:0]), .bin(bin_i[0]),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .mode(mode_i[0]),
`endif
    .busy(busy_o[0]), .done(done_o[0]), .diff(diff8), .bout(bout_o[0])
  );

  serial_sub #(.WIDTH(3)) u_w3 (
    .clk(clk), .rst(rst), .start(start_i[1]),
    .a(a_i[1][2:0]), .b(b_i[1][2:0]), .bin(bin_i[1]),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .mode(mode_i[1]),
`endif
    .busy(busy_o[1]), .done(done_o[1]), .diff(diff3), .bout(bout_o[1])
  );

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 3;
  endfunction

  // {bout,diff} as one (w+1)-bit number: plain modular arithmetic.
  function automatic logic [32:0] ref_calc(input int w, input logic [31:0] a, input logic [31:0] b,
                                           input logic bi, input logic md);
    logic [32:0] am, bm, m, r;
    m  = (33'd1 << (w + 1)) - 33'd1;
    am = {1'b0, a} & (m >> 1);
    bm = {1'b0, b} & (m >> 1);
    r  = md ? (am + bm + 33'(bi)) : (am - bm - 33'(bi));
    return r & m;
  endfunction

  function automatic logic [32:0] dut_res(input int i);
    return (i == 0) ? {24'd0, bout_o[0], diff8} : {29'd0, bout_o[1], diff3};
  endfunction

  task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted op occupies edges acc..acc+w+1; result appears after edge acc+w.
  int           cyc = 0;
  bit           act [2];
  int           acc [2];
  logic [32:0]  pend [2];
  logic [32:0]  exp_res [2];
  logic         mdl_mode;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        act[i]     <= 1'b0;
        exp_res[i] <= '0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (act[i]) begin
          if (cyc - acc[i] == wid(i)) exp_res[i] <= pend[i];
          else if (cyc - acc[i] == wid(i) + 1) act[i] <= 1'b0;
        end else if (start_i[i]) begin
`ifdef SERIAL_SUB_ADD_MODE_EN
          mdl_mode = mode_i[i];
`else
          mdl_mode = 1'b0;
`endif
          act[i]  <= 1'b1;
          acc[i]  <= cyc;
          pend[i] <= ref_calc(wid(i), a_i[i], b_i[i], bin_i[i], mdl_mode);
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        int e;
        e = cyc - acc[i];
        check($sformatf("busy%0d", i), {32'd0, busy_o[i]}, {32'd0, act[i] && (e <= wid(i))});
        check($sformatf("done%0d", i), {32'd0, done_o[i]}, {32'd0, act[i] && (e == wid(i) + 1)});
        check($sformatf("res%0d", i), dut_res(i), exp_res[i]);
      end
    end
  end

  task automatic drive_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic bi, input logic md);
    @(negedge clk);
    start_i[i] = 1'b1;
    a_i[i]     = a;
    b_i[i]     = b;
    bin_i[i]   = bi;
`ifdef SERIAL_SUB_ADD_MODE_EN
    mode_i[i]  = md;
`else
    if (md) $display("note: mode ignored in subtract-only build");
`endif
    @(negedge clk);
    start_i[i] = 1'b0;
    a_i[i]     = $urandom;
    b_i[i]     = $urandom;
    bin_i[i]   = 1'($urandom);
  endtask

  task automatic wait_done(input int i);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done_o[i]) seen = 1'b1;
    end
    check("done_timeout", {32'd0, seen}, 33'd1);
  endtask

  task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic bi, input logic md);
    drive_op(i, a, b, bi, md);
    wait_done(i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_done;
    repeat (2) @(negedge clk);
    check("rst_busy", {32'd0, busy_o[0]}, 33'd0);
    check("rst_done", {32'd0, done_o[0]}, 33'd0);
    check("rst_res8", dut_res(0), 33'd0);
    check("rst_res3", dut_res(1), 33'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    run_op(0, 32'h5A, 32'h3C, 1'b0, 1'b0);
    check("lit_5a_3c", dut_res(0), 33'h01E);
    run_op(0, 32'h00, 32'h01, 1'b0, 1'b0);
    check("lit_00_01", dut_res(0), 33'h1FF);
    run_op(0, 32'h10, 32'h10, 1'b1, 1'b0);
    check("lit_10_10_b", dut_res(0), 33'h1FF);
    run_op(0, 32'hA7, 32'hA7, 1'b0, 1'b0);
    check("lit_eq", dut_res(0), 33'h000);
    run_op(0, 32'h00, 32'hFF, 1'b1, 1'b0);
    check("lit_wrap", dut_res(0), 33'h100);

    // start re-pulsed in RUN cycle 3 with other operands: must be ignored
    drive_op(0, 32'h33, 32'h11, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    start_i[0] = 1'b1; a_i[0] = 32'hFF; b_i[0] = 32'h00;
    @(negedge clk);
    start_i[0] = 1'b0;
    wait_done(0);
    check("lit_ignore", dut_res(0), 33'h022);
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_o[0]) seen_done++;
    end
    check("no_extra_done", 33'(seen_done), 33'd0);

    // reset in the middle of an operation
    drive_op(0, 32'h77, 32'h12, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {32'd0, busy_o[0]}, 33'd0);
    check("midrst_done", {32'd0, done_o[0]}, 33'd0);
    check("midrst_res", dut_res(0), 33'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (12) @(negedge clk);
    run_op(0, 32'h80, 32'h01, 1'b0, 1'b0);
    check("lit_after_rst", dut_res(0), 33'h07F);

`ifdef SERIAL_SUB_ADD_MODE_EN
    run_op(0, 32'hF0, 32'h20, 1'b0, 1'b1);
    check("lit_add", dut_res(0), 33'h110);
    run_op(0, 32'hF0, 32'h20, 1'b0, 1'b0);
    check("lit_sub", dut_res(0), 33'h0D0);
`endif

    // start held high with changing operands: back-to-back accepts
    @(negedge clk);
    start_i[0] = 1'b1;
    repeat (40) begin
      a_i[0] = $urandom; b_i[0] = $urandom; bin_i[0] = 1'($urandom);
`ifdef SERIAL_SUB_ADD_MODE_EN
      mode_i[0] = 1'($urandom);
`endif
      @(negedge clk);
    end
    start_i[0] = 1'b0;
    repeat (12) @(negedge clk);

    repeat (40) run_op(0, $urandom, $urandom, 1'($urandom), 1'($urandom));

    for (int av = 0; av < 8; av++) begin
      for (int bv = 0; bv < 8; bv++) begin
        for (int ci = 0; ci < 2; ci++) begin
          run_op(1, 32'(av), 32'(bv), 1'(ci), 1'b0);
          check("w3_exh", dut_res(1), 33'((av - bv - ci) & 15));
        end
      end
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
